// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: drives a req/addr_ok/data_ok SRAM-like bus and stalls the pipeline.
// Optional DMEM_ALIGN_CHECK_EN adds misalignment exception outputs adel_mem/ades_mem.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              flush,
  input  logic [2:0]        load_store_mem,
  input  logic              unsigned_mem,
  input  logic [3:0]        mode_mem,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              mem_stall,
  output logic              mem_done,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              adel_mem,
  output logic              ades_mem,
`endif
  output logic [DATA_W-1:0] load_result
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        op_q, op_d;
  logic              uns_q, uns_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] load_result_q, load_result_d;
  logic              start_s;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic              misaligned_s;
`endif

  function automatic logic [31:0] store_data(input logic [1:0] op, input logic [31:0] w);
    case (op)
      2'b01:   store_data = {4{w[7:0]}};
      2'b10:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

  function automatic logic [1:0] size_of(input logic [1:0] op);
    case (op)
      2'b01:   size_of = 2'd0;
      2'b10:   size_of = 2'd1;
      2'b11:   size_of = 2'd2;
      default: size_of = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] op, input logic uns,
                                              input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = rd >> {a, 3'b000};
    half    = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      2'b01:   load_extend = {{24{shifted[7] & ~uns}}, shifted[7:0]};
      2'b10:   load_extend = {{16{half[15] & ~uns}}, half};
      default: load_extend = rd;
    endcase
  endfunction

  // Codes 000 and 100 are not memory operations and never start an access.
  assign start_s = (state_q == S_IDLE) && mem_valid && !flush &&
                   (load_store_mem != 3'b000) && (load_store_mem != 3'b100);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned_s = ((load_store_mem[1:0] == 2'b10) && mem_addr[0]) ||
                        ((load_store_mem[1:0] == 2'b11) && (mem_addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    size_d        = size_q;
    addr_d        = addr_q;
    wstrb_d       = wstrb_q;
    wdata_d       = wdata_q;
    op_d          = op_q;
    uns_d         = uns_q;
    kill_d        = kill_q;
    load_result_d = load_result_q;
`ifdef DMEM_ALIGN_CHECK_EN
    adel_d        = adel_q;
    ades_d        = ades_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          wr_d    = load_store_mem[2];
          size_d  = size_of(load_store_mem[1:0]);
          addr_d  = mem_addr;
          wstrb_d = load_store_mem[2] ? mode_mem : 4'b0000;
          wdata_d = store_data(load_store_mem[1:0], mem_wdata);
          op_d    = load_store_mem;
          uns_d   = unsigned_mem;
          kill_d  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
          if (misaligned_s) begin
            state_d = S_DONE;
            adel_d  = ~load_store_mem[2];
            ades_d  = load_store_mem[2];
          end else begin
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // A flush coinciding with acceptance cannot recall the request, so the response is drained.
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            if (flush) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DONE;
              if (!op_q[2]) begin
                load_result_d = load_extend(op_q[1:0], uns_q, addr_q[1:0], data_sram_rdata);
              end else begin
                load_result_d = load_result_q;
              end
            end
          end else begin
            state_d = S_WAIT;
            kill_d  = flush;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          kill_d = 1'b0;
          if (kill_q || flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!op_q[2]) begin
              load_result_d = load_extend(op_q[1:0], uns_q, addr_q[1:0], data_sram_rdata);
            end else begin
              load_result_d = load_result_q;
            end
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef DMEM_ALIGN_CHECK_EN
        adel_d  = 1'b0;
        ades_d  = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      wr_q          <= 1'b0;
      size_q        <= 2'd0;
      addr_q        <= '0;
      wstrb_q       <= 4'b0000;
      wdata_q       <= '0;
      op_q          <= 3'b000;
      uns_q         <= 1'b0;
      kill_q        <= 1'b0;
      load_result_q <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      adel_q        <= 1'b0;
      ades_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      size_q        <= size_d;
      addr_q        <= addr_d;
      wstrb_q       <= wstrb_d;
      wdata_q       <= wdata_d;
      op_q          <= op_d;
      uns_q         <= uns_d;
      kill_q        <= kill_d;
      load_result_q <= load_result_d;
`ifdef DMEM_ALIGN_CHECK_EN
      adel_q        <= adel_d;
      ades_q        <= ades_d;
`endif
    end
  end

  assign data_sram_req   = (state_q == S_REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;
  assign mem_done        = (state_q == S_DONE);
  assign mem_stall       = (state_q == S_REQ) || (state_q == S_WAIT) || start_s;
  assign load_result     = load_result_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign adel_mem        = adel_q;
  assign ades_mem        = ades_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard testbench for dmem_access_ctrl; honours DMEM_ALIGN_CHECK_EN when defined.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        flush;
  logic [2:0]  load_store_mem;
  logic        unsigned_mem;
  logic [3:0]  mode_mem;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_stall;
  logic        mem_done;
  logic [31:0] load_result;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        adel_mem;
  logic        ades_mem;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_lr = 32'h0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .flush(flush),
    .load_store_mem(load_store_mem), .unsigned_mem(unsigned_mem), .mode_mem(mode_mem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
`ifdef DMEM_ALIGN_CHECK_EN
    .adel_mem(adel_mem), .ades_mem(ades_mem),
`endif
    .load_result(load_result)
  );

  function automatic logic [31:0] ld_model(input logic [2:0] code, input logic uns,
                                           input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (code)
      3'b001:  return uns ? {24'h0, b} : {{24{b[7]}}, b};
      3'b010:  return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  task automatic idle_inputs();
    mem_valid = 1'b0; flush = 1'b0; load_store_mem = 3'b000; unsigned_mem = 1'b0;
    mode_mem = 4'b0000; mem_addr = 32'h0; mem_wdata = 32'h0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A5A5A;
  endtask

  // Drives one access over a fixed 14-cycle window while acting as the bus slave.
  task automatic run_txn(input string name, input logic [2:0] code, input logic uns,
                         input logic [3:0] mode, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                         input logic [31:0] rd_val, input int aok_dly, input int dok_dly,
                         input int flush_cyc, input bit exp_done, input int exp_req_cyc,
                         input int exp_stall);
    int req_cyc = 0, stall_cyc = 0, done_cyc = 0, wait_cnt = 0;
    bit accepted = 1'b0, resp = 1'b0;
    logic [31:0] exp_lr, exp_wd, e;
    logic [1:0]  exp_sz;
    logic [3:0]  exp_st;
    exp_sz = (code[1:0] == 2'b01) ? 2'd0 : (code[1:0] == 2'b10) ? 2'd1 : 2'd2;
    exp_st = code[2] ? mode : 4'b0000;
    exp_wd = (code[1:0] == 2'b01) ? {4{a_wdata[7:0]}} :
             (code[1:0] == 2'b10) ? {2{a_wdata[15:0]}} : a_wdata;
    if (exp_done) begin
      exp_lr = code[2] ? last_lr : ld_model(code, uns, a_addr[1:0], rd_val);
      exp_q.push_back(exp_lr);
      last_lr = exp_lr;
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mem_valid = 1'b1; load_store_mem = code; unsigned_mem = uns; mode_mem = mode;
        mem_addr = a_addr; mem_wdata = a_wdata;
      end else begin
        mem_valid = 1'b0; load_store_mem = 3'b000; unsigned_mem = ~uns; mode_mem = 4'b0000;
        mem_addr = 32'hFFFF_FFFF; mem_wdata = ~a_wdata;
      end
      flush = (c == flush_cyc);
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A5A5A;
      if (data_sram_req && !accepted) begin
        req_cyc++;
        n_checks++;
        if ({data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb} !==
              {code[2], exp_sz, a_addr, exp_st} || (code[2] && data_sram_wdata !== exp_wd))
          $display("FAIL %s payload: got wr=%b size=%0d addr=%h wstrb=%b wdata=%h, want wr=%b size=%0d addr=%h wstrb=%b wdata=%h",
                   name, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
                   code[2], exp_sz, a_addr, exp_st, exp_wd);
        else n_pass++;
        if (req_cyc == aok_dly + 1) begin
          data_sram_addr_ok = 1'b1;
          accepted = 1'b1;
          if (dok_dly == 0) begin
            data_sram_data_ok = 1'b1; data_sram_rdata = rd_val; resp = 1'b1;
          end
        end
      end else if (accepted && !resp) begin
        wait_cnt++;
        if (wait_cnt == dok_dly) begin
          data_sram_data_ok = 1'b1; data_sram_rdata = rd_val; resp = 1'b1;
        end
      end
      #1;
      if (mem_stall) stall_cyc++;
      if (mem_done) begin
        done_cyc++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL %s unexpected_done: got mem_done=1, want 0", name);
        else begin
          e = exp_q.pop_front();
          if (load_result !== e) $display("FAIL %s load_result: got %h, want %h", name, load_result, e);
          else n_pass++;
        end
      end
    end
    idle_inputs();
    n_checks++;
    if (req_cyc !== exp_req_cyc) $display("FAIL %s req_cycles: got %0d, want %0d", name, req_cyc, exp_req_cyc);
    else n_pass++;
    n_checks++;
    if (done_cyc !== int'(exp_done)) $display("FAIL %s done_count: got %0d, want %0d", name, done_cyc, exp_done);
    else n_pass++;
    if (exp_stall >= 0) begin
      n_checks++;
      if (stall_cyc !== exp_stall) $display("FAIL %s stall_cycles: got %0d, want %0d", name, stall_cyc, exp_stall);
      else n_pass++;
    end
    n_checks++;
    if (load_result !== last_lr || data_sram_req !== 1'b0)
      $display("FAIL %s end_state: got lr=%h req=%b, want lr=%h req=0", name, load_result, data_sram_req, last_lr);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
         mem_stall, mem_done, load_result} !== 104'h0)
      $display("FAIL reset_values: got req=%b wr=%b size=%0d addr=%h wstrb=%b wdata=%h stall=%b done=%b lr=%h, want all 0",
               data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
               mem_stall, mem_done, load_result);
    else n_pass++;
    resetn = 1'b1;
    last_lr = 32'h0;
  endtask

  task automatic test_store();
    run_txn("sw", 3'b111, 1'b0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, -1, 1'b1, 1, 4);
    run_txn("sb", 3'b101, 1'b0, 4'b1000, 32'h103, 32'h000000A5, 32'h0, 1, 1, -1, 1'b1, 2, 4);
    run_txn("sh", 3'b110, 1'b0, 4'b1100, 32'h102, 32'h1234CAFE, 32'h0, 0, 1, -1, 1'b1, 1, 3);
  endtask

  task automatic test_load();
    run_txn("lb", 3'b001, 1'b0, 4'b0000, 32'h102, 32'h0, 32'h12F45678, 0, 1, -1, 1'b1, 1, 3);
    run_txn("lbu", 3'b001, 1'b1, 4'b0000, 32'h102, 32'h0, 32'h12F45678, 0, 1, -1, 1'b1, 1, 3);
    run_txn("lh_slow", 3'b010, 1'b0, 4'b0000, 32'h102, 32'h0, 32'h8001ABCD, 5, 1, -1, 1'b1, 6, 8);
    run_txn("lhu", 3'b010, 1'b1, 4'b0000, 32'h100, 32'h0, 32'h8001ABCD, 1, 2, -1, 1'b1, 2, 5);
    run_txn("lw", 3'b011, 1'b0, 4'b0000, 32'h104, 32'h0, 32'hC0FFEE11, 0, 3, -1, 1'b1, 1, 5);
  endtask

  task automatic test_no_access();
    run_txn("code000", 3'b000, 1'b0, 4'b1111, 32'h100, 32'h0, 32'h0, 0, 0, -1, 1'b0, 0, 0);
    run_txn("code100", 3'b100, 1'b0, 4'b1111, 32'h100, 32'h0, 32'h0, 0, 0, -1, 1'b0, 0, 0);
    run_txn("flush_idle", 3'b011, 1'b0, 4'b0000, 32'h100, 32'h0, 32'h0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic test_flush();
    run_txn("flush_req", 3'b011, 1'b0, 4'b0000, 32'h100, 32'h0, 32'h11111111, 10, 1, 2, 1'b0, 2, 3);
    run_txn("flush_wait", 3'b011, 1'b0, 4'b0000, 32'h100, 32'h0, 32'h22222222, 0, 3, 3, 1'b0, 1, 5);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_lb", 3'b001, 1'b0, 4'b0000, 32'h201, 32'h0, 32'h00008000, 0, 0, -1, 1'b1, 1, 2);
    run_txn("b2b_lh", 3'b010, 1'b0, 4'b0000, 32'h200, 32'h0, 32'h00007FFF, 0, 0, -1, 1'b1, 1, 2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_valid = 1'b1; load_store_mem = 3'b011; mem_addr = 32'h300;
    @(negedge clk);
    idle_inputs();
    data_sram_addr_ok = data_sram_req;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({data_sram_req, data_sram_addr, mem_stall, mem_done, load_result} !== 67'h0)
      $display("FAIL reset_mid: got req=%b addr=%h stall=%b done=%b lr=%h, want all 0",
               data_sram_req, data_sram_addr, mem_stall, mem_done, load_result);
    else n_pass++;
    last_lr = 32'h0;
    resetn = 1'b1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h33333333;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if (mem_done !== 1'b0 || data_sram_req !== 1'b0 || load_result !== 32'h0)
      $display("FAIL late_data_ok: got done=%b req=%b lr=%h, want 0 0 0", mem_done, data_sram_req, load_result);
    else n_pass++;
  endtask

  task automatic test_misaligned();
`ifdef DMEM_ALIGN_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_valid = 1'b1; load_store_mem = (k == 0) ? 3'b011 : 3'b111; mode_mem = 4'b1111;
      mem_addr = 32'h102; mem_wdata = 32'h44444444;
      #1;
      n_checks++;
      if (mem_stall !== 1'b1) $display("FAIL misaligned_stall: got %b, want 1", mem_stall);
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++;
      if ({data_sram_req, mem_done, adel_mem, ades_mem, mem_stall} !== {1'b0, 1'b1, k == 0, k == 1, 1'b0} ||
          load_result !== last_lr)
        $display("FAIL misaligned_exc%0d: got req=%b done=%b adel=%b ades=%b lr=%h, want req=0 done=1 adel=%b ades=%b lr=%h",
                 k, data_sram_req, mem_done, adel_mem, ades_mem, load_result, k == 0, k == 1, last_lr);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if ({mem_done, adel_mem, ades_mem, data_sram_req} !== 4'b0000)
        $display("FAIL misaligned_clear%0d: got done=%b adel=%b ades=%b req=%b, want 0", k,
                 mem_done, adel_mem, ades_mem, data_sram_req);
      else n_pass++;
    end
`else
    run_txn("lw_misaligned", 3'b011, 1'b0, 4'b1111, 32'h102, 32'h0, 32'h89ABCDEF, 0, 1, -1, 1'b1, 1, 3);
`endif
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    test_reset();
    test_store();
    test_load();
    test_no_access();
    test_flush();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
